// File: rtl/seq_mul_shift_add.sv
// ============================================================================
// seq_mul_shift_add -- iterative shift-and-add unsigned multiplier.
//
// Computes product = (a * b) mod 2^N, one multiplier bit per clock, using a
// single adder32 instance (cin tied low) as the accumulation adder.
//
// Configuration macro:
//   SEQ_MUL_EARLY_TERM_EN  when defined, BUSY ends as soon as the remaining
//                          multiplier bits are all zero, and b==0 skips BUSY.
//                          Undefined (default): fixed N-step BUSY phase.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a/b operands valid
//   in_ready   out  operands can be accepted (IDLE only)
//   a          in   [N-1:0] multiplicand
//   b          in   [N-1:0] multiplier
//   out_valid  out  product valid (DONE only)
//   out_ready  in   sink accepts product
//   product    out  [N-1:0] (a*b) mod 2^N, last value held outside DONE
//   busy       out  high while stepping (BUSY)
//
// Also contains adder32, the N-bit wrap-around adder used by the multiplier.
// ============================================================================

// N-bit adder without carry-out; the sum wraps modulo 2^N.
module adder32 #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] out
);

   // Carry-in is zero-extended so every operand is N bits wide.
   assign out = a + b + {{(N-1){1'b0}}, cin};

endmodule

module seq_mul_shift_add #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] product,
   output logic         busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q,     state_d;
   logic [N-1:0]  mcand_q,     mcand_d;
   logic [N-1:0]  mplier_q,    mplier_d;
   logic [N-1:0]  acc_q,       acc_d;
   logic [N-1:0]  product_q,   product_d;
   logic [CW-1:0] count_q,     count_d;
   logic          in_ready_q,  in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q,      busy_d;

   logic [N-1:0]  sum_s;
   logic          accept_s;
   logic          last_step_s;

   // Accumulation adder: acc + current (shifted) multiplicand.
   adder32 #(.N(N)) u_adder (
      .a   (acc_q),
      .b   (mcand_q),
      .cin (1'b0),
      .out (sum_s)
   );

   assign accept_s = in_valid && in_ready_q;

`ifdef SEQ_MUL_EARLY_TERM_EN
   // Stop once no set multiplier bits remain above the one consumed this step.
   assign last_step_s = (count_q == CW'(N - 1)) ||
                        (mplier_q[N-1:1] == {(N-1){1'b0}});
`else
   assign last_step_s = (count_q == CW'(N - 1));
`endif

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mcand_q     <= {N{1'b0}};
         mplier_q    <= {N{1'b0}};
         acc_q       <= {N{1'b0}};
         count_q     <= {CW{1'b0}};
         product_q   <= {N{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         product_q   <= product_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and shift-add step logic.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      count_d  = count_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               mcand_d  = a;
               mplier_d = b;
               acc_d    = {N{1'b0}};
               count_d  = {CW{1'b0}};
`ifdef SEQ_MUL_EARLY_TERM_EN
               if (b == {N{1'b0}}) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
               end
`else
               state_d  = ST_BUSY;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mplier_q[0]) begin
               acc_d = sum_s;
            end else begin
               acc_d = acc_q;
            end
            mcand_d  = {mcand_q[N-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[N-1:1]};
            count_d  = count_q + CW'(1);
            if (last_step_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered output values derived from the upcoming state.
   always_comb begin
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d == ST_BUSY);
      // Product latches the final accumulator only on entry to DONE.
      if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
         product_d = acc_d;
      end else begin
         product_d = product_q;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = product_q;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
module tb_seq_mul_shift_add;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] product;
   logic        busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb[$];

   seq_mul_shift_add #(.N(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Cycle (1 = first cycle after the accept edge) in which out_valid is high.
   function automatic int exp_lat(input logic [31:0] bv);
`ifdef SEQ_MUL_EARLY_TERM_EN
      int msb;
      msb = -1;
      for (int i = 0; i < 32; i++) if (bv[i]) msb = i;
      return msb + 2;
`else
      return 33;
`endif
   endfunction

   task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                         input int stall, input bit keep_ready, input bit pulse);
      int          cyc;
      logic [31:0] exp;
      @(negedge clk);
      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      a = av; b = bv; in_valid = 1'b1;
      out_ready = keep_ready;
      sb.push_back(av * bv);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = ~av; b = ~bv;               // operands must already be captured
      cyc = 1;
      @(negedge clk);
      while (!out_valid && cyc < 200) begin
         chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
         chk("busy_flag",     {31'd0, busy},     32'd1);
         in_valid = pulse && (cyc == 2);
         a = 32'd9; b = 32'd9;
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      chk("latency", cyc, exp_lat(bv));
      if (sb.size() == 0) begin
         chk("sb_nonempty", 32'd0, 32'd1);
         return;
      end
      exp = sb.pop_front();
      if (!out_valid) begin
         chk("timeout", 32'd0, 32'd1);
         rst_n = 1'b0; #1; rst_n = 1'b1;
         return;
      end
      chk("product",       product,          exp);
      chk("busy_done",     {31'd0, busy},    32'd0);
      chk("in_ready_done", {31'd0, in_ready},32'd0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid",   {31'd0, out_valid}, 32'd1);
         chk("stall_product", product,            exp);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_valid",   {31'd0, out_valid}, 32'd0);
      chk("post_ready",   {31'd0, in_ready},  32'd1);
      chk("post_product", product,            exp);
      if (pulse) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_second_result", {31'd0, out_valid}, 32'd0);
         end
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          nrand;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
      #12;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_product",   product,            32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic latency, with out_ready high throughout (no effect outside DONE).
      run_op(32'd3, 32'd5, 0, 1'b1, 1'b0);
      // Wrap-around.
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
      run_op(32'h0001_0000, 32'h0001_0000, 0, 1'b0, 1'b0);
      run_op(32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'd2,         0, 1'b0, 1'b0);
      run_op(32'h8000_0000, 32'd2,         0, 1'b0, 1'b0);
      // Backpressure.
      run_op(32'd7, 32'd6, 5, 1'b0, 1'b0);
      // Ignored input while busy.
      run_op(32'd3, 32'd5, 0, 1'b0, 1'b1);
      // Zero operands and early-termination cases.
      run_op(32'd0, 32'd1234,      0, 1'b0, 1'b0);
      run_op(32'd7, 32'd1,         0, 1'b0, 1'b0);
      run_op(32'd5, 32'd0,         0, 1'b0, 1'b0);
      run_op(32'd1, 32'h8000_0000, 0, 1'b0, 1'b0);

      // Reset ten cycles into BUSY.
      @(negedge clk);
      a = 32'd7; b = 32'hFFFF_FFFF; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) @(negedge clk);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_product",   product,            32'd0);
      chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("mid_rst_busy",      {31'd0, busy},      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("rst_no_pulse", {31'd0, out_valid}, 32'd0);
      end
      run_op(32'd4, 32'd4, 0, 1'b0, 1'b0);

      // Random pairs, multiplier widths spread across all bit positions.
`ifdef SEQ_MUL_EARLY_TERM_EN
      nrand = 1000;
`else
      nrand = 150;
`endif
      for (int i = 0; i < nrand; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 32);
         run_op(ra, rb, 0, 1'b1, 1'b0);
      end

      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
